// File: rtl/segre_mem_arbiter_if.sv
// Bus bundle between the two cache miss ports, the shared lane memory and the arbiter.
// Handshake: a request is valid while *_miss_i / mem_req_o is high and completes on the cycle
// the responder answers (ic_fill_o/dc_fill_o or mem_ready_i); the requester holds it stable until then.
interface segre_mem_arbiter_if #(
  parameter int ADDR_SIZE = 32,
  parameter int LANE_SIZE = 128
);
  logic                 ic_miss_i;
  logic [ADDR_SIZE-1:0] ic_addr_i;
  logic                 dc_miss_i;
  logic [ADDR_SIZE-1:0] dc_addr_i;
  logic                 dc_wb_i;
  logic [ADDR_SIZE-1:0] dc_wb_addr_i;
  logic [LANE_SIZE-1:0] dc_wb_data_i;
  logic                 mem_req_o;
  logic                 mem_we_o;
  logic [ADDR_SIZE-1:0] mem_addr_o;
  logic [LANE_SIZE-1:0] mem_wr_data_o;
  logic                 mem_ready_i;
  logic [LANE_SIZE-1:0] mem_rd_data_i;
  logic                 ic_fill_o;
  logic                 dc_fill_o;
  logic [LANE_SIZE-1:0] fill_data_o;
  logic                 busy_o;

  modport master (
    input  ic_miss_i, ic_addr_i, dc_miss_i, dc_addr_i, dc_wb_i, dc_wb_addr_i, dc_wb_data_i,
           mem_ready_i, mem_rd_data_i,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wr_data_o, ic_fill_o, dc_fill_o, fill_data_o, busy_o
  );

  modport slave (
    output ic_miss_i, ic_addr_i, dc_miss_i, dc_addr_i, dc_wb_i, dc_wb_addr_i, dc_wb_data_i,
           mem_ready_i, mem_rd_data_i,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wr_data_o, ic_fill_o, dc_fill_o, fill_data_o, busy_o
  );
endinterface

// File: rtl/segre_mem_arbiter.sv
// Round-robin arbiter sharing one lane-wide memory port between icache and dcache misses,
// including the dcache dirty-victim writeback ahead of its refill read.
module segre_mem_arbiter #(
  parameter int ADDR_SIZE = 32,
  parameter int LANE_SIZE = 128
) (
  input  logic                clk_i,
  input  logic                rsn_i,
  segre_mem_arbiter_if.master bus,
  output logic [2:0]          dbg_state_o
);

  localparam int LANE_BYTES = LANE_SIZE / 8;
  localparam logic [ADDR_SIZE-1:0] LANE_MASK = ~ADDR_SIZE'(LANE_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DC_WB = 3'd1,
    DC_RD = 3'd2,
    IC_RD = 3'd3,
    FILL  = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic                 rr_ic_q, rr_ic_d;       // 1: icache wins the next tie
  logic                 served_dc_q, served_dc_d;
  logic [ADDR_SIZE-1:0] miss_addr_q, miss_addr_d;
  logic [ADDR_SIZE-1:0] wb_addr_q, wb_addr_d;
  logic [LANE_SIZE-1:0] wb_data_q, wb_data_d;
  logic [LANE_SIZE-1:0] fill_data_q, fill_data_d;

  logic                 grant_dc;
  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [LANE_SIZE-1:0] mem_wr_data;

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q     <= IDLE;
      rr_ic_q     <= 1'b0;
      served_dc_q <= 1'b0;
      miss_addr_q <= '0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      fill_data_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ic_q     <= rr_ic_d;
      served_dc_q <= served_dc_d;
      miss_addr_q <= miss_addr_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      fill_data_q <= fill_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ic_d     = rr_ic_q;
    served_dc_d = served_dc_q;
    miss_addr_d = miss_addr_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    fill_data_d = fill_data_q;
    grant_dc    = bus.dc_miss_i && (!bus.ic_miss_i || !rr_ic_q);

    case (state_q)
      IDLE: begin
        if (bus.dc_miss_i || bus.ic_miss_i) begin
          served_dc_d = grant_dc;
          if (grant_dc) begin
            miss_addr_d = bus.dc_addr_i & LANE_MASK;
            wb_addr_d   = bus.dc_wb_addr_i & LANE_MASK;
            wb_data_d   = bus.dc_wb_data_i;
            state_d     = bus.dc_wb_i ? DC_WB : DC_RD;
          end else begin
            miss_addr_d = bus.ic_addr_i & LANE_MASK;
            state_d     = IC_RD;
          end
        end
      end
      DC_WB: begin
        if (bus.mem_ready_i) state_d = DC_RD;
      end
      DC_RD, IC_RD: begin
        if (bus.mem_ready_i) begin
          fill_data_d = bus.mem_rd_data_i;
          state_d     = FILL;
        end
      end
      FILL: begin
        // Whoever was just served loses the next tie.
        rr_ic_d = served_dc_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory outputs come only from registers, so they are stable for the whole request.
  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    case (state_q)
      DC_WB: begin
        mem_req     = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = wb_addr_q;
        mem_wr_data = wb_data_q;
      end
      DC_RD, IC_RD: begin
        mem_req  = 1'b1;
        mem_addr = miss_addr_q;
      end
      default: ;
    endcase
  end

  assign bus.mem_req_o     = mem_req;
  assign bus.mem_we_o      = mem_we;
  assign bus.mem_addr_o    = mem_addr;
  assign bus.mem_wr_data_o = mem_wr_data;
  assign bus.ic_fill_o     = (state_q == FILL) && !served_dc_q;
  assign bus.dc_fill_o     = (state_q == FILL) && served_dc_q;
  assign bus.fill_data_o   = fill_data_q;
  assign bus.busy_o        = (state_q != IDLE);
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Random and directed stimulus for segre_mem_arbiter against a transaction-level model:
// grants from round-robin rules, expected memory operations in a queue, fills one cycle after the read.
module tb_segre_mem_arbiter;

  localparam int A   = 32;
  localparam int L   = 128;
  localparam int LB  = L / 8;
  localparam int OPW = 1 + A + L;

  // clock / reset
  logic clk_i = 1'b0;
  logic rsn_i;
  always #5 clk_i = ~clk_i;

  segre_mem_arbiter_if #(.ADDR_SIZE(A), .LANE_SIZE(L)) bus ();
  logic [2:0] dbg_state;

  segre_mem_arbiter #(.ADDR_SIZE(A), .LANE_SIZE(L)) dut (
    .clk_i       (clk_i),
    .rsn_i       (rsn_i),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // scoreboard / model state
  int total = 0;
  int bad   = 0;
  logic [OPW-1:0] exp_q[$];
  logic [L-1:0]   exp_fill_data;
  logic in_flight, fill_due, fill_dc, just_filled, last_dc;
  logic ic_granted, dc_granted, s_mem_req, timeout_hit;
  int   grant_age, req_age;

  // stimulus knobs
  int   ic_rate, dc_rate, wb_rate, ready_rate, ready_delay, drop_rate;
  logic fix_ic, fix_dc;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [L-1:0] rand_lane();
    logic [L-1:0] r;
    for (int i = 0; i < L / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [A-1:0] align(input logic [A-1:0] a);
    return a - (a % A'(LB));
  endfunction

  function automatic logic roll(input int pct);
    return int'($urandom_range(0, 99)) < pct;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   256'(bus.mem_req_o),     256'(0));
    check({tag, "_we"},    256'(bus.mem_we_o),      256'(0));
    check({tag, "_addr"},  256'(bus.mem_addr_o),    256'(0));
    check({tag, "_wdata"}, 256'(bus.mem_wr_data_o), 256'(0));
    check({tag, "_fdata"}, 256'(bus.fill_data_o),   256'(0));
    check({tag, "_icf"},   256'(bus.ic_fill_o),     256'(0));
    check({tag, "_dcf"},   256'(bus.dc_fill_o),     256'(0));
    check({tag, "_busy"},  256'(bus.busy_o),        256'(0));
  endtask

  // Compare what the DUT shows this cycle with what the model expects.
  task automatic check_outputs();
    logic exp_req;
    exp_req = (exp_q.size() != 0);
    check("busy", 256'(bus.busy_o), 256'(in_flight));
    check("mem_req", 256'(bus.mem_req_o), 256'(exp_req));
    if (bus.mem_req_o && exp_req) begin
      if (exp_q[0][OPW-1])
        check("mem_wr_op", 256'({bus.mem_we_o, bus.mem_addr_o, bus.mem_wr_data_o}), 256'(exp_q[0]));
      else
        check("mem_rd_op", 256'({bus.mem_we_o, bus.mem_addr_o}), 256'(exp_q[0][OPW-1 -: 1+A]));
    end
    check("ic_fill", 256'(bus.ic_fill_o), 256'(fill_due && !fill_dc));
    check("dc_fill", 256'(bus.dc_fill_o), 256'(fill_due && fill_dc));
    if (fill_due) check("fill_data", 256'(bus.fill_data_o), 256'(exp_fill_data));
    s_mem_req   = bus.mem_req_o;
    just_filled = fill_due;
    if (fill_due) begin
      in_flight = 1'b0;
      fill_due  = 1'b0;
      if (fill_dc) begin
        dc_granted    = 1'b0;
        bus.dc_miss_i = 1'b0;
      end else begin
        ic_granted    = 1'b0;
        bus.ic_miss_i = 1'b0;
      end
    end
    if (in_flight) begin
      grant_age++;
      if (grant_age > 200) begin
        check("timeout", 256'(1), 256'(0));
        timeout_hit = 1'b1;
      end
    end
  endtask

  // Drive caches and memory for the next edge, then advance the model.
  task automatic drive_and_model();
    logic hs, pick_dc;
    logic [OPW-1:0] op;
    if (ic_granted) begin
      bus.ic_addr_i = $urandom;
      if (bus.ic_miss_i && roll(drop_rate)) bus.ic_miss_i = 1'b0;
    end else if (!bus.ic_miss_i && roll(ic_rate)) begin
      bus.ic_miss_i = 1'b1;
      bus.ic_addr_i = fix_ic ? 32'h0000_1234 : $urandom;
    end
    if (dc_granted) begin
      bus.dc_addr_i    = $urandom;
      bus.dc_wb_i      = roll(50);
      bus.dc_wb_addr_i = $urandom;
      bus.dc_wb_data_i = rand_lane();
      if (bus.dc_miss_i && roll(drop_rate)) bus.dc_miss_i = 1'b0;
    end else if (!bus.dc_miss_i && roll(dc_rate)) begin
      bus.dc_miss_i    = 1'b1;
      bus.dc_wb_i      = fix_dc ? 1'b1 : roll(wb_rate);
      bus.dc_wb_addr_i = fix_dc ? 32'h0000_0080 : $urandom;
      bus.dc_addr_i    = fix_dc ? 32'h0000_0040 : $urandom;
      bus.dc_wb_data_i = rand_lane();
    end

    bus.mem_rd_data_i = rand_lane();
    if (ready_delay >= 0) bus.mem_ready_i = s_mem_req && (req_age >= ready_delay);
    else                  bus.mem_ready_i = roll(ready_rate);
    hs = s_mem_req && bus.mem_ready_i;
    if (s_mem_req) req_age = hs ? 0 : req_age + 1;
    if (hs && exp_q.size() != 0) begin
      op = exp_q.pop_front();
      if (!op[OPW-1]) begin
        fill_due      = 1'b1;
        exp_fill_data = bus.mem_rd_data_i;
      end
    end

    if (!in_flight && !just_filled && (bus.ic_miss_i || bus.dc_miss_i)) begin
      pick_dc   = bus.dc_miss_i && (!bus.ic_miss_i || !last_dc);
      last_dc   = pick_dc;
      fill_dc   = pick_dc;
      in_flight = 1'b1;
      grant_age = 0;
      req_age   = 0;
      if (pick_dc) begin
        dc_granted = 1'b1;
        if (bus.dc_wb_i) exp_q.push_back({1'b1, align(bus.dc_wb_addr_i), bus.dc_wb_data_i});
        exp_q.push_back({1'b0, align(bus.dc_addr_i), {L{1'b0}}});
      end else begin
        ic_granted = 1'b1;
        exp_q.push_back({1'b0, align(bus.ic_addr_i), {L{1'b0}}});
      end
    end
  endtask

  task automatic do_reset(input int hold);
    rsn_i = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    exp_q.delete();
    in_flight = 0; fill_due = 0; just_filled = 0; last_dc = 0;
    ic_granted = 0; dc_granted = 0; timeout_hit = 0;
    req_age = 0; grant_age = 0;
    repeat (hold) @(negedge clk_i);
    check_reset_outputs("rst_held");
    rsn_i     = 1'b1;
    s_mem_req = 1'b0;
    drive_and_model();
  endtask

  task automatic step();
    @(negedge clk_i);
    check_outputs();
    if (timeout_hit) do_reset(1);
    else             drive_and_model();
  endtask

  task automatic set_knobs(input int ic, input int dc, input int wb, input int rdy, input int dly,
                           input int drop, input logic fi, input logic fd);
    ic_rate = ic; dc_rate = dc; wb_rate = wb; ready_rate = rdy; ready_delay = dly;
    drop_rate = drop; fix_ic = fi; fix_dc = fd;
  endtask

  initial begin
    logic reached;
    bus.ic_miss_i = 0; bus.ic_addr_i = 0; bus.dc_miss_i = 0; bus.dc_addr_i = 0;
    bus.dc_wb_i = 0; bus.dc_wb_addr_i = 0; bus.dc_wb_data_i = 0;
    bus.mem_ready_i = 0; bus.mem_rd_data_i = 0;
    s_mem_req = 0;

    // both caches raise on the first cycle after reset and keep requesting
    set_knobs(100, 100, 50, 60, -1, 0, 1'b0, 1'b0);
    do_reset(2);
    repeat (40) step();

    // icache miss at 0x1234, memory answers after a 3-cycle delay
    set_knobs(100, 0, 0, 0, 3, 0, 1'b1, 1'b0);
    repeat (25) step();

    // dirty dcache victim at 0x80, refill from 0x40
    set_knobs(0, 100, 0, 70, -1, 0, 1'b0, 1'b1);
    repeat (25) step();

    // memory always ready, icache streaming back-to-back
    set_knobs(100, 0, 0, 100, -1, 0, 1'b0, 1'b0);
    repeat (25) step();

    // reset while a clean dcache read is waiting on memory
    set_knobs(0, 100, 0, 100, -1, 0, 1'b0, 1'b0);
    repeat (8) step();
    ready_rate = 0;
    reached = 1'b0;
    for (int i = 0; i < 60 && !reached; i++) begin
      step();
      reached = in_flight && dc_granted && exp_q.size() == 1 && !exp_q[0][OPW-1] && grant_age > 2;
    end
    check("rst_mid_setup", 256'(reached), 256'(1));
    do_reset(1);
    ready_rate = 50;
    repeat (30) step();

    // randomized traffic with in-flight drops and occasional resets
    for (int blk = 0; blk < 20; blk++) begin
      set_knobs($urandom_range(10, 100), $urandom_range(10, 100), $urandom_range(0, 100),
                $urandom_range(20, 100), -1, 5, 1'b0, 1'b0);
      if (blk % 3 == 1) ready_delay = $urandom_range(0, 3);
      repeat (100) step();
      if (blk % 5 == 4) do_reset($urandom_range(1, 3));
    end

    set_knobs(0, 0, 0, 100, -1, 0, 1'b0, 1'b0);
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/segre_mem_arbiter.md
SEGRE_MEM_ARBITER -- requirements
Module: segre_mem_arbiter

Interface
REQ-001 Parameter: ADDR_SIZE, 32, byte-address width.
REQ-002 Parameter: LANE_SIZE, 128, cache-lane width in bits; a power of two and at least 32.
REQ-003 clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 rsn_i  in  1  reset, asynchronous, active-low.
REQ-005 ic_miss_i  in  1  icache miss request, level; held until ic_fill_o.
REQ-006 ic_addr_i  in  ADDR_SIZE  icache miss byte address.
REQ-007 dc_miss_i  in  1  dcache miss request, level; held until dc_fill_o.
REQ-008 dc_addr_i  in  ADDR_SIZE  dcache miss byte address.
REQ-009 dc_wb_i  in  1  victim lane dirty; sampled with dc_miss_i at grant.
REQ-010 dc_wb_addr_i  in  ADDR_SIZE  victim lane byte address.
REQ-011 dc_wb_data_i  in  LANE_SIZE  victim lane data.
REQ-012 mem_req_o  out  1  memory request valid.
REQ-013 mem_we_o  out  1  1 = lane write, 0 = lane read.
REQ-014 mem_addr_o  out  ADDR_SIZE  lane-aligned address; the low log2(LANE_SIZE/8) bits are zero.
REQ-015 mem_wr_data_o  out  LANE_SIZE  write data.
REQ-016 mem_ready_i  in  1  memory completes the current request this cycle.
REQ-017 mem_rd_data_i  in  LANE_SIZE  read data, valid with mem_ready_i.
REQ-018 ic_fill_o  out  1  one-cycle pulse: icache lane returned.
REQ-019 dc_fill_o  out  1  one-cycle pulse: dcache lane returned.
REQ-020 fill_data_o  out  LANE_SIZE  registered lane data, valid with either fill pulse.
REQ-021 busy_o  out  1  high in every state except IDLE.

Function
REQ-022 States: IDLE, DC_WB, DC_RD, IC_RD, FILL.
REQ-023 IDLE with one request pending: grant that requester on the next edge.
REQ-024 IDLE with both requests pending: grant the requester not granted last (round-robin bit); after reset the dcache wins first.
REQ-025 At grant, addresses, dc_wb_i and write data are captured into registers; later changes on the inputs are ignored until the next grant.
REQ-026 Dcache grant with dc_wb_i=1: IDLE->DC_WB; otherwise IDLE->DC_RD. Icache grant: IDLE->IC_RD.
REQ-027 DC_WB: mem_req_o=1, mem_we_o=1, captured victim address and data; on mem_ready_i go to DC_RD.
REQ-028 DC_RD and IC_RD: mem_req_o=1, mem_we_o=0, captured miss address; on mem_ready_i latch mem_rd_data_i into fill_data_o and go to FILL.
REQ-029 FILL: pulse the matching fill output for exactly one cycle, update the round-robin bit, then return to IDLE.
REQ-030 mem_req_o and the memory address/data stay stable from request assertion until mem_ready_i; mem_ready_i is ignored in IDLE and FILL.
REQ-031 A mem_ready_i in the same cycle as the state entry completes that request; minimum miss latency is grant + 1 cycle to FILL.
REQ-032 A request dropped while its transaction is in flight still completes, and its fill pulse is still issued.
REQ-033 No new grant is made in FILL; the earliest back-to-back grant is the cycle after FILL.
REQ-034 ic_fill_o and dc_fill_o are never high together.

Reset
REQ-035 While rsn_i=0, regardless of clock: state=IDLE, round-robin points to dcache, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wr_data_o=0, fill_data_o=0, ic_fill_o=0, dc_fill_o=0, busy_o=0.
REQ-036 Reset asserted mid-transaction aborts it without any fill pulse; requests still held after release are re-arbitrated from IDLE.

Verification
REQ-037 ic_miss_i=1, ic_addr_i=0x0000_1234, mem_ready_i delayed 3 cycles -> mem_addr_o=0x0000_1230, mem_we_o=0; one ic_fill_o pulse with fill_data_o=mem_rd_data_i.
REQ-038 dc_miss_i=1, dc_wb_i=1, dc_wb_addr_i=0x80, dc_addr_i=0x40 -> write to 0x80 with dc_wb_data_i, then read of 0x40, then one dc_fill_o pulse.
REQ-039 Both requests raised together on the first cycle after reset -> dcache served first, icache next; the second grant comes the cycle after the first FILL.
REQ-040 Both requests held continuously -> grants alternate DC, IC, DC, IC across 4 transactions.
REQ-041 rsn_i pulsed low during DC_RD -> all outputs return to 0 immediately, no dc_fill_o; the held dc_miss_i is re-served after release.
REQ-042 mem_ready_i=1 constantly with ic_miss_i held -> IC_RD lasts 1 cycle, FILL 1 cycle; a new grant every 3 cycles.
